// File: rtl/mem_stage_if.sv
// MEM-stage port bundle: the EX->MEM inputs, the stall vector, SRAM read data and
// the MEM->WB / forwarding outputs. The master drives the stage and the slave is the stage.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 80,
  parameter int MEM_TO_WB_WD = 70,
  parameter int HILO_WD      = 66
) ();
  logic [5:0]              stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [HILO_WD-1:0]      hilo_ex_to_mem;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_to_id;
  logic                    mem_is_load;
  logic [HILO_WD-1:0]      hilo_mem_to_wb;
  logic [HILO_WD-1:0]      hilo_mem_to_id;
  logic                    mem_addr_err;

  modport master (
    output stall, ex_to_mem_bus, hilo_ex_to_mem, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id, mem_is_load, hilo_mem_to_wb, hilo_mem_to_id,
           mem_addr_err
  );

  modport slave (
    input  stall, ex_to_mem_bus, hilo_ex_to_mem, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id, mem_is_load, hilo_mem_to_wb, hilo_mem_to_id,
           mem_addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: registers EX->MEM and HI/LO, extracts load data with a stall-safe hold word.
// Optional macro MEM_UNALIGNED_CHK_EN flags misaligned lh/lhu/lw and suppresses their register write.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 80,
  parameter int MEM_TO_WB_WD = 70,
  parameter int HILO_WD      = 66
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  mem_if
);

  localparam logic [3:0] RD_LB  = 4'b0001;
  localparam logic [3:0] RD_LBU = 4'b0010;
  localparam logic [3:0] RD_LH  = 4'b0011;
  localparam logic [3:0] RD_LHU = 4'b0100;
  localparam logic [3:0] RD_LW  = 4'b1111;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_reg;
  logic [HILO_WD-1:0]      hilo_reg;
  logic                    hold_valid_reg;
  logic [31:0]             hold_data_reg;

  logic [3:0]  readen;
  logic [31:0] pc;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  addr_lo;

  assign readen     = ex_to_mem_bus_reg[79:76];
  assign pc         = ex_to_mem_bus_reg[75:44];
  assign sel_rf_res = ex_to_mem_bus_reg[38];
  assign rf_we      = ex_to_mem_bus_reg[37];
  assign rf_waddr   = ex_to_mem_bus_reg[36:32];
  assign ex_result  = ex_to_mem_bus_reg[31:0];
  assign addr_lo    = ex_result[1:0];

  logic is_load;
  logic take_bubble;
  logic take_new;
  logic capture;

  always_comb begin
    is_load = 1'b0;
    case (readen)
      RD_LB, RD_LBU, RD_LH, RD_LHU, RD_LW: is_load = 1'b1;
      default:                            is_load = 1'b0;
    endcase
  end

  assign take_bubble = mem_if.stall[3] && !mem_if.stall[4];
  assign take_new    = !mem_if.stall[3];
  // Grab the SRAM word only once per stalled residency; later cycles may see unrelated reads.
  assign capture     = is_load && !hold_valid_reg && mem_if.stall[3] && mem_if.stall[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_to_mem_bus_reg <= '0;
      hilo_reg          <= '0;
      hold_valid_reg    <= 1'b0;
      hold_data_reg     <= 32'h0;
    end else if (take_bubble) begin
      ex_to_mem_bus_reg <= '0;
      hilo_reg          <= '0;
      hold_valid_reg    <= 1'b0;
    end else if (take_new) begin
      ex_to_mem_bus_reg <= mem_if.ex_to_mem_bus;
      hilo_reg          <= mem_if.hilo_ex_to_mem;
      hold_valid_reg    <= 1'b0;
    end else if (capture) begin
      hold_valid_reg    <= 1'b1;
      hold_data_reg     <= mem_if.data_sram_rdata;
    end
  end

  logic [31:0] load_word;
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign load_word = hold_valid_reg ? hold_data_reg : mem_if.data_sram_rdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_lane[gi] = load_word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[addr_lo];
  assign sel_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (readen)
      RD_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      RD_LBU:  load_data = {24'h0, sel_byte};
      RD_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      RD_LHU:  load_data = {16'h0, sel_half};
      RD_LW:   load_data = load_word;
      default: load_data = 32'h0;
    endcase
  end

  logic addr_err;

`ifdef MEM_UNALIGNED_CHK_EN
  always_comb begin
    addr_err = 1'b0;
    case (readen)
      RD_LH, RD_LHU: addr_err = addr_lo[0];
      RD_LW:         addr_err = (addr_lo != 2'b00);
      default:       addr_err = 1'b0;
    endcase
  end
`else
  assign addr_err = 1'b0;
`endif

  logic        rf_we_eff;
  logic [31:0] rf_wdata;

  assign rf_we_eff = rf_we && !addr_err;
  assign rf_wdata  = sel_rf_res ? load_data : ex_result;

  assign mem_if.mem_to_wb_bus  = {pc, rf_we_eff, rf_waddr, rf_wdata};
  assign mem_if.mem_to_id      = {rf_we_eff, rf_waddr, rf_wdata};
  assign mem_if.mem_is_load    = is_load;
  assign mem_if.hilo_mem_to_wb = hilo_reg;
  assign mem_if.hilo_mem_to_id = hilo_reg;
  assign mem_if.mem_addr_err   = addr_err;

  // ram_en/ram_wen were consumed by the SRAM request in EX; other stall bits belong to other stages.
  logic unused_bits;
  assign unused_bits = ^{ex_to_mem_bus_reg[43:39], mem_if.stall[5], mem_if.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed test-plan cases followed by random stall/load traffic.
// Honours MEM_UNALIGNED_CHK_EN the same way the design does.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if mif ();
  mem_stage dut (.clk(clk), .rst(rst), .mem_if(mif));

  typedef struct packed {
    logic [69:0] wb;
    logic [37:0] id;
    logic        ld;
    logic [65:0] hwb;
    logic [65:0] hid;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: the instruction sitting in MEM, whether this is its first cycle there,
  // and the SRAM word it saw on that first cycle.
  logic        m_valid = 1'b0;
  logic [79:0] m_bus;
  logic [65:0] m_hilo;
  logic        m_fresh;
  logic [31:0] m_word;
  logic [79:0] p_bus;
  logic [65:0] p_hilo;
  logic        p_fresh;
  logic [31:0] p_word;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic is_ld(input logic [3:0] re);
    return re == 4'd1 || re == 4'd2 || re == 4'd3 || re == 4'd4 || re == 4'd15;
  endfunction

  function automatic logic [31:0] ld_val(input logic [3:0] re, input logic [31:0] w, input logic [1:0] a);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (a[1] ? (w >> 16) : w) & 32'hFFFF;
    case (re)
      4'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      4'd4:    return h;
      4'd15:   return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t model_out(input logic [79:0] b, input logic [65:0] hl, input logic [31:0] w);
    exp_t e;
    logic err;
    logic [3:0] re;
    logic [31:0] wd;
    re  = b[79:76];
    err = 1'b0;
`ifdef MEM_UNALIGNED_CHK_EN
    if ((re == 4'd3 || re == 4'd4) && b[0]) err = 1'b1;
    if (re == 4'd15 && b[1:0] != 2'b00) err = 1'b1;
`endif
    wd    = b[38] ? ld_val(re, w, b[1:0]) : b[31:0];
    e.wb  = {b[75:44], b[37] & ~err, b[36:32], wd};
    e.id  = e.wb[37:0];
    e.ld  = is_ld(re);
    e.hwb = hl;
    e.hid = hl;
    e.err = err;
    return e;
  endfunction

  function automatic logic [79:0] mk(input logic [3:0] re, input logic [31:0] pc, input logic sel,
                                     input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {re, pc, 1'b0, 4'b0000, sel, we, wa, res};
  endfunction

  // Apply one cycle of inputs, queue the expected outputs, and work out the next MEM contents.
  task automatic drive(input logic r, input logic [5:0] s, input logic [79:0] b,
                       input logic [65:0] h, input logic [31:0] d);
    rst                 = r;
    mif.stall           = s;
    mif.ex_to_mem_bus   = b;
    mif.hilo_ex_to_mem  = h;
    mif.data_sram_rdata = d;
    if (m_valid) exp_q.push_back(model_out(m_bus, m_hilo, m_fresh ? d : m_word));
    p_bus = m_bus; p_hilo = m_hilo; p_fresh = m_fresh; p_word = m_word;
    if (r || (s[3] && !s[4])) begin
      p_bus = '0; p_hilo = '0; p_fresh = 1'b1;
    end else if (!s[3]) begin
      p_bus = b; p_hilo = h; p_fresh = 1'b1;
    end else begin
      if (m_fresh) p_word = d;
      p_fresh = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) m_valid = 1'b1;
    m_bus = p_bus; m_hilo = p_hilo; m_fresh = p_fresh; m_word = p_word;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_mem_to_wb", mif.mem_to_wb_bus, e.wb);
        chk("sb_mem_to_id", 70'(mif.mem_to_id), 70'(e.id));
        chk("sb_is_load", 70'(mif.mem_is_load), 70'(e.ld));
        chk("sb_hilo_wb", 70'(mif.hilo_mem_to_wb), 70'(e.hwb));
        chk("sb_hilo_id", 70'(mif.hilo_mem_to_id), 70'(e.hid));
        chk("sb_addr_err", 70'(mif.mem_addr_err), 70'(e.err));
      end
    end
  end

  initial begin : stim
    logic [3:0]  codes [9];
    logic [3:0]  re;
    logic [79:0] rb;
    logic [65:0] rh;
    logic [5:0]  rs;
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15, 4'd5, 4'd7, 4'd9};
    rst = 1'b1;
    mif.stall = '0; mif.ex_to_mem_bus = '0; mif.hilo_ex_to_mem = '0; mif.data_sram_rdata = '0;
    @(posedge clk); #1;

    drive(1'b1, 6'b0, 80'h0, 66'h0, 32'h0); step();
    drive(1'b0, 6'b0, mk(4'd1, 32'h40, 1'b1, 1'b1, 5'd3, 32'h0000_0102), 66'h0, 32'h0);
    #3;
    chk("rst_mem_to_wb", mif.mem_to_wb_bus, 70'h0);
    chk("rst_hilo_wb", 70'(mif.hilo_mem_to_wb), 70'h0);
    chk("rst_is_load", 70'(mif.mem_is_load), 70'h0);
    chk("rst_hold_valid", 70'(dut.hold_valid_reg), 70'h0);
    step();
    drive(1'b0, 6'b0, mk(4'd2, 32'h44, 1'b1, 1'b1, 5'd4, 32'h0000_0102), 66'h0, 32'h1280_3456);
    #3; chk("lb_sext", 70'(mif.mem_to_wb_bus[31:0]), 70'h0000_0000_FFFF_FF80); step();
    drive(1'b0, 6'b0, mk(4'd3, 32'h48, 1'b1, 1'b1, 5'd5, 32'h0000_0202), 66'h0, 32'h1280_3456);
    #3; chk("lbu_zext", 70'(mif.mem_to_wb_bus[31:0]), 70'h0000_0080); step();
    drive(1'b0, 6'b0, mk(4'd15, 32'h4C, 1'b1, 1'b1, 5'd6, 32'h0000_0300), 66'h0, 32'h8001_7FFF);
    #3; chk("lh_hi_sext", 70'(mif.mem_to_wb_bus[31:0]), 70'hFFFF_8001); step();
    drive(1'b0, 6'b0, mk(4'd0, 32'h50, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF), 66'h0, 32'h8001_7FFF);
    #3; chk("lw_pass", 70'(mif.mem_to_wb_bus[31:0]), 70'h8001_7FFF); step();
    drive(1'b0, 6'b0, mk(4'd15, 32'h54, 1'b1, 1'b1, 5'd8, 32'h0000_0100), 66'h0, 32'h0);
    #3; chk("alu_pass", 70'(mif.mem_to_wb_bus[31:0]), 70'hDEAD_BEEF); step();
    drive(1'b0, 6'b011000, 80'h0, 66'h0, 32'hCAFE_0001);
    #3; chk("hold_c0", 70'(mif.mem_to_wb_bus[31:0]), 70'hCAFE_0001); step();
    for (int i = 1; i < 3; i++) begin
      drive(1'b0, 6'b011000, 80'h0, 66'h0, 32'h0);
      #3; chk($sformatf("hold_c%0d", i), 70'(mif.mem_to_wb_bus[31:0]), 70'hCAFE_0001); step();
    end
    drive(1'b0, 6'b0, mk(4'd15, 32'h58, 1'b1, 1'b1, 5'd9, 32'h0000_0200), {2'b11, 32'h5, 32'h7}, 32'h0);
    #3; chk("hold_release", 70'(mif.mem_to_wb_bus[31:0]), 70'hCAFE_0001); step();
    drive(1'b0, 6'b001000, 80'h0, 66'h0, 32'h1234_5678);
    #3;
    chk("hold_cleared", 70'(dut.hold_valid_reg), 70'h0);
    chk("after_hold_data", 70'(mif.mem_to_wb_bus[31:0]), 70'h1234_5678);
    chk("hilo_before_bubble", 70'(mif.hilo_mem_to_wb), 70'({2'b11, 32'h5, 32'h7}));
    step();
    drive(1'b0, 6'b0, mk(4'd15, 32'h5C, 1'b1, 1'b1, 5'd10, 32'h1000_0002), 66'h0, 32'hAABB_CCDD);
    #3;
    chk("bubble_rf_we", 70'(mif.mem_to_wb_bus[37]), 70'h0);
    chk("bubble_hilo_we", 70'(mif.hilo_mem_to_wb[65:64]), 70'h0);
    chk("bubble_pc", 70'(mif.mem_to_wb_bus[69:38]), 70'h0);
    step();
    drive(1'b0, 6'b0, 80'h0, 66'h0, 32'h0);
    #3;
`ifdef MEM_UNALIGNED_CHK_EN
    chk("unaligned_err", 70'(mif.mem_addr_err), 70'h1);
    chk("unaligned_we", 70'(mif.mem_to_wb_bus[37]), 70'h0);
`else
    chk("unaligned_err", 70'(mif.mem_addr_err), 70'h0);
    chk("unaligned_we", 70'(mif.mem_to_wb_bus[37]), 70'h1);
`endif
    step();

    for (int n = 0; n < 500; n++) begin
      re = codes[$urandom_range(0, 8)];
      rb = mk(re, $urandom, is_ld(re), 1'($urandom), 5'($urandom), $urandom);
      rb[43:39] = 5'($urandom);
      rh = {2'($urandom), $urandom, $urandom};
      rs = 6'($urandom);
      drive(($urandom_range(0, 39) == 0), rs, rb, rh, $urandom);
      step();
    end

    @(negedge clk);
    chk("queue_drained", 70'(exp_q.size()), 70'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX stage.
- Registers the EX→MEM bus and the HI/LO write bundle, consumes the synchronous data-SRAM read data, and performs load byte/halfword extraction with sign or zero extension.
- Produces the MEM→WB bus plus forwarding buses back to ID.
- Holds load data across stall cycles so a stalled load never loses its SRAM word.

Parameters:
- EX_TO_MEM_WD, 80, width of incoming EX→MEM bus
- MEM_TO_WB_WD, 70, width of outgoing MEM→WB bus
- HILO_WD, 66, width of HI/LO bundle {hi_we, lo_we, hi[31:0], lo[31:0]}

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active-high
- stall  in  6  pipeline stall vector; bit 3 = MEM, bit 4 = WB; 1 = Stop
- ex_to_mem_bus  in  80  {readen[79:76], pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- hilo_ex_to_mem  in  66  HI/LO write bundle from EX
- data_sram_rdata  in  32  SRAM read word, valid the cycle the access is in MEM
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- mem_to_id  out  38  {rf_we, rf_waddr, rf_wdata} forwarding
- mem_is_load  out  1  registered instruction is a load (readen ∈ load codes)
- hilo_mem_to_wb  out  66  registered HI/LO bundle
- hilo_mem_to_id  out  66  same bundle, forwarding copy
- mem_addr_err  out  1  misaligned load detected (see Optional Feature)

Behaviour:
- Reset: one clock with rst=1 clears both internal registers, hold_valid and hold_data to 0. Every output reads 0 after that edge.
- Bus register update, priority order:
  - rst.
  - stall[3]=1 && stall[4]=0: load all-zero bubble (both buses).
  - stall[3]=0: load ex_to_mem_bus and hilo_ex_to_mem.
  - Otherwise: hold.
- readen codes:
  - 0000 none
  - 0001 lb
  - 0010 lbu
  - 0011 lh
  - 0100 lhu
  - 1111 lw
  - 0101 sb and 0111 sh are store markers and are treated as non-load
  - Any other code is treated as non-load.
- Load data source: held word w = hold_valid ? hold_data : data_sram_rdata.
- Byte select uses addr[1:0] = ex_result[1:0]:
  - lb/lbu take w[8k+7:8k], where k = addr[1:0].
  - lh/lhu take w[15:0] when addr[1]=0, else w[31:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes w unchanged.
- rf_wdata = sel_rf_res ? extracted load data : ex_result. This is purely combinational from the registered bus and w (0-cycle latency in MEM).
- Hold buffer (the stall-safety mechanism):
  - Captures data_sram_rdata when the registered instruction is a load, hold_valid=0, and the MEM register will not advance next edge (stall[3]=1 && stall[4]=1).
  - On capture, set hold_valid=1.
  - Clear hold_valid on any edge where the register loads new contents or a bubble, or on rst.
  - While hold_valid=1, data_sram_rdata is ignored.
- Forwarding:
  - mem_to_id equals mem_to_wb_bus[37:0] in the same cycle.
  - hilo_mem_to_id equals hilo_mem_to_wb.
- Bubble outputs have rf_we=0, hi_we=lo_we=0 and pc=0, so ID forwarding never matches a bubble.
- Simultaneous bubble and capture cannot occur: a bubble requires stall[4]=0.
- Reset mid-stall discards the held data.

Optional Feature:
- Macro MEM_UNALIGNED_CHK_EN.
- Defined:
  - mem_addr_err=1 combinationally when (lh|lhu) with addr[0]=1, or lw with addr[1:0]≠00.
  - When flagged, rf_we in both outputs is forced to 0 and the write is suppressed.
- Undefined:
  - mem_addr_err is tied to 0 and no gating is applied.
  - Misaligned halfword/word loads then use the extraction rules above (lw returns w unchanged).

Test Plan:
- Reset: rst=1 one cycle → all outputs 0; mem_to_wb_bus=70'h0, hold_valid=0.
- lb sign extension: lb, addr=...02, rdata=32'h1280_3456, stall=0 → rf_wdata=32'hFFFF_FF80.
  - Same with lbu → 32'h0000_0080.
- lh/lw/ALU passthrough:
  - lh, addr[1]=1, rdata=32'h8001_7FFF → 32'hFFFF_8001.
  - lw → 32'h8001_7FFF.
  - ALU op (sel_rf_res=0, ex_result=32'hDEAD_BEEF) → 32'hDEAD_BEEF.
- Stall hold:
  - Setup: lw in MEM with rdata=32'hCAFE_0001, then stall=6'b011000 for 3 cycles while rdata changes to 32'h0.
  - Required: rf_wdata stays 32'hCAFE_0001 throughout and after release.
  - Required: hold_valid clears on the advancing edge.
- Bubble: stall=6'b001000 (MEM stop, WB go) → next cycle rf_we=0 and hi_we=lo_we=0.
  - Prior HI/LO bundle {1,1,32'h5,32'h7} observed on hilo_mem_to_wb the cycle before.
- With MEM_UNALIGNED_CHK_EN: lw addr=32'h1000_0002 → mem_addr_err=1, rf_we=0.
  - Same stimulus without the macro → mem_addr_err=0, rf_we=1.
